// File: rtl/fft_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_stream_ctrl
// Brief    : Streaming front end for fft_top. Loads N_PTS real samples from a
//            valid/ready stream into the four external-load RAM banks, pulses
//            the core start, waits for completion, then streams the four real
//            result banks back out through a 4-entry output FIFO.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N_PTS   transform length (4 banks x N_PTS/4 words), default 2048
//   RD_LAT  bank read latency in cycles, address to iFFT_DATA_RE_x (1..3)
// Ports
//   iCLK, iRESET            clock, synchronous active-low reset
//   iS_DATA/VALID, oS_READY sample input stream
//   oM_DATA/VALID/LAST,
//   iM_READY                result output stream (17-bit signed real part)
//   oFFT_DATA, oFFT_ADDR_WR_x,
//   oFFT_WE_x               bank write port (data broadcast to all banks)
//   oFFT_ADDR_RD_x,
//   iFFT_DATA_RE_x          bank read port
//   oFFT_START, iFFT_RDY    core start pulse / done level
//   oBUSY                   high whenever the controller is not idle
// Build option
//   FFT_OUT_SAT_EN          when defined, results are clipped to the signed
//                           16-bit range before leaving on oM_DATA
// ============================================================================
module fft_stream_ctrl #(
    parameter int N_PTS  = 2048,
    parameter int RD_LAT = 1
) (
    input  logic                        iCLK,
    input  logic                        iRESET,
    input  logic [15:0]                 iS_DATA,
    input  logic                        iS_VALID,
    output logic                        oS_READY,
    output logic signed [16:0]          oM_DATA,
    output logic                        oM_VALID,
    input  logic                        iM_READY,
    output logic                        oM_LAST,
    output logic [15:0]                 oFFT_DATA,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_WR_0,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_WR_1,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_WR_2,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_WR_3,
    output logic                        oFFT_WE_0,
    output logic                        oFFT_WE_1,
    output logic                        oFFT_WE_2,
    output logic                        oFFT_WE_3,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_RD_0,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_RD_1,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_RD_2,
    output logic [$clog2(N_PTS)-3:0]    oFFT_ADDR_RD_3,
    output logic                        oFFT_START,
    input  logic signed [16:0]          iFFT_DATA_RE_0,
    input  logic signed [16:0]          iFFT_DATA_RE_1,
    input  logic signed [16:0]          iFFT_DATA_RE_2,
    input  logic signed [16:0]          iFFT_DATA_RE_3,
    input  logic                        iFFT_RDY,
    output logic                        oBUSY
);

    localparam int                 c_IDX_W    = $clog2(N_PTS);
    localparam int                 c_AW       = c_IDX_W - 2;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_PTS - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOAD      = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_ST_UNLOAD    = 3'd5;

    logic [2:0]          r_state;
    logic                r_s_ready;
    logic [c_IDX_W-1:0]  r_wr_idx;
    logic [15:0]         r_fft_data;
    logic [c_AW-1:0]     r_addr_wr;
    logic [3:0]          r_we;
    logic                r_start;

    // Read side: r_rd_idx is the result index k; its upper bits drive the
    // read address directly, so a read "issues" in the cycle the address is
    // on the port and the data returns RD_LAT cycles later.
    logic [c_IDX_W-1:0]  r_rd_idx;
    logic                r_rd_done;
    logic [RD_LAT-1:0]   r_pipe_v;
    logic [RD_LAT-1:0]   r_pipe_last;
    logic [1:0]          r_pipe_bank [RD_LAT];

    logic signed [16:0]  r_mem_data [4];
    logic [3:0]          r_mem_last;
    logic [1:0]          r_wp;
    logic [1:0]          r_rp;
    logic [2:0]          r_count;

    logic                w_s_acc;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [2:0]          w_inflight;
    logic [3:0]          w_used;
    logic signed [16:0]  w_cap_data;
    logic signed [16:0]  w_head_data;
    logic                w_head_last;

    assign w_s_acc     = iS_VALID & r_s_ready;
    assign w_valid     = (r_count != 3'd0);
    assign w_pop       = w_valid & iM_READY;
    assign w_push      = r_pipe_v[RD_LAT-1];
    assign w_head_data = r_mem_data[r_rp];
    assign w_head_last = r_mem_last[r_rp];

    always_comb begin
        w_inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + {2'b00, r_pipe_v[i]};
        end
    end

    // Slots committed after this edge: FIFO entries that stay plus reads
    // still travelling through the RAM. A slot freed by this cycle's pop is
    // reusable immediately, which is what sustains one result per cycle.
    assign w_used  = {1'b0, r_count} + {1'b0, w_inflight} - {3'b000, w_pop};
    assign w_issue = (r_state == c_ST_UNLOAD) && !r_rd_done && (w_used < 4'd4);

    always_comb begin
        case (r_pipe_bank[RD_LAT-1])
            2'd0:    w_cap_data = iFFT_DATA_RE_0;
            2'd1:    w_cap_data = iFFT_DATA_RE_1;
            2'd2:    w_cap_data = iFFT_DATA_RE_2;
            default: w_cap_data = iFFT_DATA_RE_3;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_state     <= c_ST_IDLE;
            r_s_ready   <= 1'b0;
            r_wr_idx    <= '0;
            r_fft_data  <= '0;
            r_addr_wr   <= '0;
            r_we        <= '0;
            r_start     <= 1'b0;
            r_rd_idx    <= '0;
            r_rd_done   <= 1'b0;
            r_pipe_v    <= '0;
            r_pipe_last <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_bank[i] <= 2'd0;
            end
            for (int i = 0; i < 4; i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_last  <= '0;
            r_wp        <= 2'd0;
            r_rp        <= 2'd0;
            r_count     <= 3'd0;
        end else begin
            r_we    <= 4'b0000;
            r_start <= 1'b0;

            // Write path: the counter only moves on accepted beats, so the
            // bank/address mapping stays dense regardless of input gaps.
            // The final increment wraps the counter back to 0 for next frame.
            if (w_s_acc) begin
                r_fft_data <= iS_DATA;
                r_addr_wr  <= r_wr_idx[c_IDX_W-1:2];
                r_we       <= 4'b0001 << r_wr_idx[1:0];
                r_wr_idx   <= r_wr_idx + 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_s_acc) begin
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (w_s_acc && (r_wr_idx == c_LAST_IDX)) begin
                        r_s_ready <= 1'b0;
                        r_state   <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_start <= 1'b1;
                    r_state <= c_ST_WAIT_BUSY;
                end
                c_ST_WAIT_BUSY: begin
                    if (!iFFT_RDY) begin
                        r_state <= c_ST_WAIT_DONE;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (iFFT_RDY) begin
                        r_rd_idx  <= '0;
                        r_rd_done <= 1'b0;
                        r_state   <= c_ST_UNLOAD;
                    end
                end
                c_ST_UNLOAD: begin
                    if (w_pop && w_head_last) begin
                        r_s_ready <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            if (w_issue) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (r_rd_idx == c_LAST_IDX) begin
                    r_rd_done <= 1'b1;
                end
            end

            // Bank select and last flag travel alongside the RAM latency.
            r_pipe_v[0]    <= w_issue;
            r_pipe_bank[0] <= r_rd_idx[1:0];
            r_pipe_last[0] <= (r_rd_idx == c_LAST_IDX);
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_bank[i] <= r_pipe_bank[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end

            if (w_push) begin
                r_mem_data[r_wp] <= w_cap_data;
                r_mem_last[r_wp] <= r_pipe_last[RD_LAT-1];
                r_wp             <= r_wp + 2'd1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 2'd1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

`ifdef FFT_OUT_SAT_EN
    always_comb begin
        if (w_head_data > 17'sd32767) begin
            oM_DATA = 17'sd32767;
        end else if (w_head_data < -17'sd32768) begin
            oM_DATA = -17'sd32768;
        end else begin
            oM_DATA = w_head_data;
        end
    end
`else
    assign oM_DATA = w_head_data;
`endif

    assign oS_READY       = r_s_ready;
    assign oM_VALID       = w_valid;
    assign oM_LAST        = w_valid & w_head_last;
    assign oFFT_DATA      = r_fft_data;
    assign oFFT_ADDR_WR_0 = r_addr_wr;
    assign oFFT_ADDR_WR_1 = r_addr_wr;
    assign oFFT_ADDR_WR_2 = r_addr_wr;
    assign oFFT_ADDR_WR_3 = r_addr_wr;
    assign oFFT_WE_0      = r_we[0];
    assign oFFT_WE_1      = r_we[1];
    assign oFFT_WE_2      = r_we[2];
    assign oFFT_WE_3      = r_we[3];
    assign oFFT_ADDR_RD_0 = r_rd_idx[c_IDX_W-1:2];
    assign oFFT_ADDR_RD_1 = r_rd_idx[c_IDX_W-1:2];
    assign oFFT_ADDR_RD_2 = r_rd_idx[c_IDX_W-1:2];
    assign oFFT_ADDR_RD_3 = r_rd_idx[c_IDX_W-1:2];
    assign oFFT_START     = r_start;
    assign oBUSY          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stream_ctrl
// Brief    : Directed self-checking bench for fft_stream_ctrl (N_PTS=2048,
//            RD_LAT=2) with a behavioural core-handshake model and a bank
//            model returning b*1000+addr (or +/-40000 in saturation mode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stream_ctrl;

    logic               clk;
    logic               rst_n;
    logic [15:0]        s_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [16:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic [15:0]        fft_data;
    logic [8:0]         wr0, wr1, wr2, wr3;
    logic               we0, we1, we2, we3;
    logic [8:0]         rd0, rd1, rd2, rd3;
    logic               fft_start;
    logic signed [16:0] re0, re1, re2, re3;
    logic               fft_rdy = 1'b1;
    logic               busy;
    logic [3:0]         we;

    int  n_vec = 0;
    int  n_err = 0;
    bit  sat_mode = 1'b0;
    int  busy_cnt = 0;

    logic signed [16:0] rx_data [2048];
    logic               rx_last [2048];

    fft_stream_ctrl #(.N_PTS(2048), .RD_LAT(2)) dut (
        .iCLK(clk), .iRESET(rst_n),
        .iS_DATA(s_data), .iS_VALID(s_valid), .oS_READY(s_ready),
        .oM_DATA(m_data), .oM_VALID(m_valid), .iM_READY(m_ready), .oM_LAST(m_last),
        .oFFT_DATA(fft_data),
        .oFFT_ADDR_WR_0(wr0), .oFFT_ADDR_WR_1(wr1), .oFFT_ADDR_WR_2(wr2), .oFFT_ADDR_WR_3(wr3),
        .oFFT_WE_0(we0), .oFFT_WE_1(we1), .oFFT_WE_2(we2), .oFFT_WE_3(we3),
        .oFFT_ADDR_RD_0(rd0), .oFFT_ADDR_RD_1(rd1), .oFFT_ADDR_RD_2(rd2), .oFFT_ADDR_RD_3(rd3),
        .oFFT_START(fft_start),
        .iFFT_DATA_RE_0(re0), .iFFT_DATA_RE_1(re1), .iFFT_DATA_RE_2(re2), .iFFT_DATA_RE_3(re3),
        .iFFT_RDY(fft_rdy), .oBUSY(busy)
    );

    assign we = {we3, we2, we1, we0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: busy (rdy low) for 100 cycles after each start pulse.
    always @(posedge clk) begin
        if (fft_start) begin
            fft_rdy  <= 1'b0;
            busy_cnt <= 100;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) fft_rdy <= 1'b1;
        end
    end

    // Bank model with two cycles of read latency.
    logic [8:0] a_d1 [4];
    logic [8:0] a_d2 [4];
    always @(posedge clk) begin
        a_d1[0] <= rd0; a_d1[1] <= rd1; a_d1[2] <= rd2; a_d1[3] <= rd3;
        for (int b = 0; b < 4; b++) a_d2[b] <= a_d1[b];
    end

    function automatic logic signed [16:0] bank_val(input bit sat, input int b, input logic [8:0] a);
        if (sat) return (b % 2 == 0) ? 17'sd40000 : -17'sd40000;
        return 17'(b * 1000 + int'(a));
    endfunction

    assign re0 = bank_val(sat_mode, 0, a_d2[0]);
    assign re1 = bank_val(sat_mode, 1, a_d2[1]);
    assign re2 = bank_val(sat_mode, 2, a_d2[2]);
    assign re3 = bank_val(sat_mode, 3, a_d2[3]);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Stimulus helper: drives one frame of ramp samples, optionally with a
    // one-cycle gap after every beat.
    task automatic load_frame(input bit gaps);
        for (int n = 0; n < 2048; n++) begin
            s_valid = 1'b1;
            s_data  = 16'(n);
            @(negedge clk);
            if (gaps) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    // Stimulus helper: drives iM_READY and records accepted beats into
    // rx_data/rx_last. Returns at the negedge preceding the edge that accepts
    // the last beat (or beat index stop_at).
    task automatic unload_frame(input int pct, input int stop_at,
                                output int nb, output int unstable, output bit tmo);
        logic signed [16:0] prev_d;
        bit prev_hold;
        nb = 0; unstable = 0; tmo = 1'b0; prev_hold = 1'b0; prev_d = '0;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            m_ready = (pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < pct);
            if (prev_hold && (!m_valid || m_data !== prev_d)) unstable++;
            prev_hold = m_valid && !m_ready;
            prev_d    = m_data;
            if (m_valid && m_ready) begin
                if (nb < 2048) begin
                    rx_data[nb] = m_data;
                    rx_last[nb] = m_last;
                end
                nb++;
                if (m_last || (nb - 1 == stop_at)) return;
            end
            @(negedge clk);
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({s_ready, m_valid, m_last, busy, fft_start} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000", {s_ready, m_valid, m_last, busy, fft_start});
        end
        n_vec++;
        if ({m_data, fft_data, we} !== 37'b0) begin
            n_err++;
            $display("FAIL reset_data: got m_data=%0d fft_data=%0d we=%b expected 0", m_data, fft_data, we);
        end
        n_vec++;
        if ({wr0, wr1, wr2, wr3, rd0, rd1, rd2, rd3} !== 72'b0) begin
            n_err++;
            $display("FAIL reset_addr: got %h expected 0", {wr0, wr1, wr2, wr3, rd0, rd1, rd2, rd3});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", s_ready, busy);
        end
    endtask

    task automatic test_load_ramp;
        int errs;
        errs = 0;
        for (int n = 0; n < 2048; n++) begin
            s_valid = 1'b1;
            s_data  = 16'(n);
            @(negedge clk);
            if (we !== (4'b0001 << (n % 4)) || wr0 !== 9'(n / 4) || wr1 !== 9'(n / 4) ||
                wr2 !== 9'(n / 4) || wr3 !== 9'(n / 4) || fft_data !== 16'(n)) errs++;
            if (n < 2047 && s_ready !== 1'b1) errs++;
            if (n == 5) begin
                n_vec++;
                if (we !== 4'b0010 || wr1 !== 9'd1 || fft_data !== 16'd5 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL load_sample5: got we=%b addr=%0d data=%0d busy=%b expected we=0010 addr=1 data=5 busy=1",
                             we, wr1, fft_data, busy);
                end
            end
            if (n == 2047) begin
                n_vec++;
                if (we !== 4'b1000 || wr3 !== 9'd511 || fft_start !== 1'b0 || s_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_sample2047: got we=%b addr=%0d start=%b ready=%b expected we=1000 addr=511 start=0 ready=0",
                             we, wr3, fft_start, s_ready);
                end
            end
        end
        s_valid = 1'b0;
        n_vec++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL load_ramp_writes: got %0d bad write cycles expected 0", errs);
        end
        @(negedge clk);
        n_vec++;
        if (fft_start !== 1'b1 || we !== 4'b0) begin
            n_err++;
            $display("FAIL start_pulse: got start=%b we=%b expected start=1 we=0000", fft_start, we);
        end
        @(negedge clk);
        n_vec++;
        if (fft_start !== 1'b0) begin
            n_err++;
            $display("FAIL start_width: got start=%b expected 0", fft_start);
        end
    endtask

    task automatic test_unload_order;
        int nb, unstable, errs, lerrs;
        bit tmo;
        logic signed [16:0] exp;
        unload_frame(100, -1, nb, unstable, tmo);
        errs = 0; lerrs = 0;
        for (int k = 0; k < 2048; k++) begin
            exp = 17'((k % 4) * 1000 + k / 4);
            if (rx_data[k] !== exp) errs++;
            if (rx_last[k] !== (k == 2047)) lerrs++;
        end
        n_vec++;
        if (tmo || nb != 2048) begin
            n_err++;
            $display("FAIL unload_count: got %0d beats timeout=%0d expected 2048 timeout=0", nb, tmo);
        end
        n_vec++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL unload_data: got %0d wrong beats (k5=%0d) expected 0 (k5=1001)", errs, rx_data[5]);
        end
        n_vec++;
        if (lerrs != 0) begin
            n_err++;
            $display("FAIL unload_last: got %0d wrong last flags expected 0", lerrs);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL unload_exit: got busy=%b ready=%b valid=%b expected 0 1 0", busy, s_ready, m_valid);
        end
    endtask

    task automatic test_input_gaps;
        int errs, writes;
        logic [8:0] held;
        errs = 0; writes = 0;
        for (int n = 0; n < 2048; n++) begin
            s_valid = 1'b1;
            s_data  = 16'(n);
            @(negedge clk);
            if (we != 4'b0) writes++;
            if (we !== (4'b0001 << (n % 4)) || wr0 !== 9'(n / 4) || fft_data !== 16'(n)) errs++;
            held = wr0;
            s_valid = 1'b0;
            @(negedge clk);
            if (we != 4'b0) writes++;
            if (we !== 4'b0 || wr0 !== held) errs++;
        end
        n_vec++;
        if (writes != 2048) begin
            n_err++;
            $display("FAIL gaps_write_count: got %0d expected 2048", writes);
        end
        n_vec++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL gaps_write_pattern: got %0d bad cycles expected 0", errs);
        end
        test_unload_order();
    endtask

    task automatic test_backpressure;
        int nb, unstable, errs;
        bit tmo;
        logic signed [16:0] exp;
        load_frame(1'b0);
        unload_frame(30, -1, nb, unstable, tmo);
        m_ready = 1'b1;
        errs = 0;
        for (int k = 0; k < 2048; k++) begin
            exp = 17'((k % 4) * 1000 + k / 4);
            if (rx_data[k] !== exp || rx_last[k] !== (k == 2047)) errs++;
        end
        n_vec++;
        if (tmo || nb != 2048) begin
            n_err++;
            $display("FAIL bp_count: got %0d beats timeout=%0d expected 2048 timeout=0", nb, tmo);
        end
        n_vec++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL bp_sequence: got %0d wrong beats expected 0", errs);
        end
        n_vec++;
        if (unstable != 0) begin
            n_err++;
            $display("FAIL bp_hold_stable: got %0d unstable holds expected 0", unstable);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_exit: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_unload;
        int nb, unstable, errs;
        bit tmo;
        logic signed [16:0] exp;
        load_frame(1'b0);
        unload_frame(100, 700, nb, unstable, tmo);
        n_vec++;
        if (tmo || nb != 701) begin
            n_err++;
            $display("FAIL midrst_reach: got %0d beats expected 701", nb);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({s_ready, m_valid, m_last, busy, fft_start, we} !== 9'b0 || m_data !== 17'sd0 ||
            fft_data !== 16'd0 || {wr0, wr1, wr2, wr3, rd0, rd1, rd2, rd3} !== 72'b0) begin
            n_err++;
            $display("FAIL midrst_values: got ready=%b valid=%b last=%b busy=%b data=%0d rd0=%0d expected all 0",
                     s_ready, m_valid, m_last, busy, m_data, rd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_release: got ready=%b expected 1", s_ready);
        end
        load_frame(1'b0);
        unload_frame(100, -1, nb, unstable, tmo);
        errs = 0;
        for (int k = 0; k < 2048; k++) begin
            exp = 17'((k % 4) * 1000 + k / 4);
            if (rx_data[k] !== exp || rx_last[k] !== (k == 2047)) errs++;
        end
        n_vec++;
        if (tmo || nb != 2048 || errs != 0) begin
            n_err++;
            $display("FAIL midrst_new_frame: got %0d beats %0d wrong expected 2048 beats 0 wrong", nb, errs);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        int nb, unstable, errs;
        bit tmo;
        logic signed [16:0] exp_pos, exp_neg;
`ifdef FFT_OUT_SAT_EN
        exp_pos = 17'sd32767;
        exp_neg = -17'sd32768;
`else
        exp_pos = 17'sd40000;
        exp_neg = -17'sd40000;
`endif
        load_frame(1'b0);
        sat_mode = 1'b1;
        unload_frame(100, -1, nb, unstable, tmo);
        @(negedge clk);
        sat_mode = 1'b0;
        n_vec++;
        if (rx_data[0] !== exp_pos) begin
            n_err++;
            $display("FAIL sat_positive: got %0d expected %0d", rx_data[0], exp_pos);
        end
        n_vec++;
        if (rx_data[1] !== exp_neg) begin
            n_err++;
            $display("FAIL sat_negative: got %0d expected %0d", rx_data[1], exp_neg);
        end
        errs = 0;
        for (int k = 0; k < 2048; k++) begin
            if (rx_data[k] !== ((k % 2 == 0) ? exp_pos : exp_neg)) errs++;
        end
        n_vec++;
        if (tmo || nb != 2048 || errs != 0) begin
            n_err++;
            $display("FAIL sat_frame: got %0d beats %0d wrong expected 2048 beats 0 wrong", nb, errs);
        end
    endtask

    initial begin
        test_reset();
        test_load_ramp();
        test_unload_order();
        test_input_gaps();
        test_backpressure();
        test_reset_mid_unload();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_stream_ctrl.md
# fft_stream_ctrl

Host-side streaming front end for `fft_top`. It accepts real 16-bit time samples on a valid/ready stream and writes them into the four external-load RAM banks. It then pulses start, waits for the transform to finish, and reads the four real result banks back out as a valid/ready stream. It owns the `iDATA` / `iADDR_WR_x` / `iWE_x` / `iADDR_RD_x` / `oDATA_RE_x` / `iSTART` / `oRDY` side of the core.

## Interface
Parameters:
- `N_PTS`, 2048: transform length, `4 × 512`; the index counter is `log2(N_PTS)` bits.
- `RD_LAT`, 1: FFT RAM read latency in cycles (1..3), address to `iFFT_DATA_RE_x`.

Ports:
- `iCLK`  in  1  clock (single clock domain).
- `iRESET`  in  1  synchronous, active-low reset.
- `iS_DATA`  in  16  input sample.
- `iS_VALID`  in  1  sample valid.
- `oS_READY`  out  1  sample ready.
- `oM_DATA`  out  17  result, real part, signed.
- `oM_VALID`  out  1  result valid.
- `iM_READY`  in  1  result ready.
- `oM_LAST`  out  1  marks the final result beat.
- `oFFT_DATA`  out  16  write data, broadcast to all banks.
- `oFFT_ADDR_WR_0..3`  out  9 each  bank write addresses.
- `oFFT_WE_0..3`  out  1 each  bank write enables.
- `oFFT_ADDR_RD_0..3`  out  9 each  bank read addresses.
- `oFFT_START`  out  1  start pulse to the core.
- `iFFT_DATA_RE_0..3`  in  17 each  bank read data.
- `iFFT_RDY`  in  1  core done/idle level.
- `oBUSY`  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD.
- **IDLE:** `oS_READY=1`. The first accepted beat is sample 0 and moves the FSM to LOAD.
- **IDLE/LOAD write path:**
  - An accepted beat `n` (`iS_VALID & oS_READY`) is written through registered outputs.
  - `oFFT_WE_b=1` only for bank `b = n[1:0]`.
  - All four `oFFT_ADDR_WR_x = n[10:2]`; `oFFT_DATA = iS_DATA`.
  - Cycles with no accepted beat: all WE=0, and the counter holds.
- **LOAD → START:** after beat `N_PTS-1` is accepted, `oS_READY` drops.
- **START:** `oFFT_START=1` for exactly one cycle, then WAIT_BUSY.
- **WAIT_BUSY:** waits for `iFFT_RDY=0`, then WAIT_DONE.
- **WAIT_DONE:** waits for `iFFT_RDY=1`, then UNLOAD. No timeout.
- **UNLOAD read path:**
  - Result index `k` counts 0..`N_PTS-1`.
  - Issue: all four `oFFT_ADDR_RD_x = k[10:2]`. The bank select `k[1:0]` and a last flag are delayed `RD_LAT` cycles alongside.
  - Capture: the selected `iFFT_DATA_RE_b` is pushed into a 4-entry output FIFO.
  - Flow control: a read is issued only if `(FIFO occupancy + reads in flight) < 4`. No result is ever dropped or duplicated.
  - Output: `oM_DATA` / `oM_VALID` / `oM_LAST` come from the FIFO head, registered. `oM_DATA` stays stable while `oM_VALID & !iM_READY`.
  - Exit: when the beat with `oM_LAST=1` is accepted, the FSM returns to IDLE, `oBUSY=0`, and `oS_READY=1` the next cycle.
- **Sample ready rule:** `oS_READY=0` in START, WAIT_BUSY, WAIT_DONE and UNLOAD. Input is never accepted while a frame is being unloaded.
- **Reset:** reset at any state, including mid-LOAD or mid-UNLOAD, abandons the frame. The FIFO and counters clear; the FSM goes to IDLE.

## Timing
- **Reset values:** `oS_READY=0`, `oM_VALID=0`, `oM_LAST=0`, `oM_DATA=0`, `oFFT_DATA=0`, all `oFFT_ADDR_WR_x=0`, all `oFFT_WE_x=0`, all `oFFT_ADDR_RD_x=0`, `oFFT_START=0`, `oBUSY=0`.
- **After reset release:** `oS_READY=1` on the first cycle.
- **Write latency:** a beat accepted at cycle t produces WE/address/data at t+1.
- **Start pulse:** the last write occurs at t+1; `oFFT_START=1` at t+2.
- **Read latency:** a read issued at cycle r enters the FIFO at r+`RD_LAT`. `oM_VALID` rises no earlier than r+`RD_LAT`+1.
- **Throughput:** with `iM_READY` held high, one result per cycle after the initial latency.
- **FIFO boundaries:**
  - Push and pop in the same cycle are allowed.
  - Full: no issue that cycle.
  - Empty: `oM_VALID=0`.

## Configuration
- **`FFT_OUT_SAT_EN` defined:** the FIFO head is clipped to the 16-bit range, presented sign-extended on the 17-bit port.
  - Values > 32767 become 32767.
  - Values < −32768 become −32768.
- **`FFT_OUT_SAT_EN` undefined:** the 17-bit value passes through unmodified. The clip logic is not generated.

## Test plan
- **Load pattern:** ramp 0..2047 with `iS_VALID` held 1.
  - Sample 5 → `oFFT_WE_1` only, `ADDR_WR=1`, `oFFT_DATA=5`.
  - Sample 2047 → `oFFT_WE_3`, `ADDR_WR=511`.
  - `oFFT_START` high for exactly one cycle, one cycle after that write.
- **Input gaps:** `iS_VALID` toggles every cycle → 2048 writes total. WE is 0 on idle cycles, and addresses advance only on accepted beats.
- **Unload order:** core model drops `iFFT_RDY` for 100 cycles, then raises it. Bank model returns `b*1000+addr` with `RD_LAT=2`; `iM_READY=1`.
  - Result k = `(k%4)*1000 + k/4`, 2048 beats.
  - `oM_LAST` set only on k=2047.
  - `oBUSY` drops after the last beat.
- **Backpressure:** random `iM_READY` (30% high) → identical sequence to the unload-order case. No loss, no duplicates. `oM_DATA` stable whenever held.
- **Reset mid-unload:** `iRESET=0` at output beat 700 → all outputs at reset values next cycle; `oS_READY=1` the first cycle after release. A new frame then completes correctly.
- **Saturation:** bank returns +40000 and −40000.
  - With `FFT_OUT_SAT_EN`: outputs 32767 / −32768.
  - Without: outputs 40000 / −40000.
